mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage consumer of the EX/MEM pipeline register: turns its mem_read/mem_write, address (ALU result) and store data into a
//  valid/ready data-memory bus transaction. Formats load data (byte/half/word, signed/unsigned) for MEM/WB and stalls the pipeline
//  until the access completes. One access in flight; sits between ex_mem and the data memory / bus fabric.
// PARAMETERS
//  TIMEOUT_CYCLES  256  max cycles waiting in REQ or WAIT before bus_error; 0 disables the timeout.
// PORTS
//  clk            in   1   single clock, all state on posedge
//  reset_n        in   1   asynchronous, active-low reset
//  ex_mem_read    in   1   load request from EX/MEM
//  ex_mem_write   in   1   store request from EX/MEM (never high together with ex_mem_read)
//  ex_addr        in   32  byte address (EX/MEM alu_result)
//  ex_wdata       in   32  store data (EX/MEM rs2_data)
//  ex_funct3      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  mem_stall      out  1   hold IF..EX/MEM while high
//  dmem_req_valid out  1   bus request valid
//  dmem_req_ready in   1   bus accepts request when valid&ready
//  dmem_we        out  1   1 = write
//  dmem_addr      out  32  word-aligned address ({ex_addr[31:2],2'b00})
//  dmem_wdata     out  32  store data lane-replicated
//  dmem_wstrb     out  4   byte enables
//  dmem_rsp_valid in   1   read-data valid (loads only)
//  dmem_rdata     in   32  read word
//  load_data      out  32  formatted load result, valid when load_valid
//  load_valid     out  1   1-cycle pulse, load result ready
//  misalign_fault out  1   1-cycle pulse, misaligned access rejected
//  bus_error      out  1   1-cycle pulse, timeout abort
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (load_data 0, dmem_* 0, mem_stall 0); timeout counter 0. Async assert, sync release.
//  FSM IDLE->REQ->(WAIT)->DONE->IDLE.
//  IDLE: op = read|write. op & misaligned (H with addr[0]=1, W with addr[1:0]!=0) -> misalign_fault next cycle, no bus cycle,
//   state IDLE, mem_stall 0. op & aligned -> mem_stall=1 combinationally this cycle; latch addr/wdata/funct3/we; go REQ.
//  REQ: dmem_req_valid=1, outputs stable until handshake. valid&ready: store -> DONE; load -> WAIT. rsp_valid in REQ ignored.
//  WAIT: await dmem_rsp_valid (earliest the cycle after acceptance); capture formatted data -> DONE.
//  DONE: mem_stall=0; load_valid=1 for loads; load_data held until next load captures. -> IDLE. EX/MEM advances at end of
//   DONE, so the same op is not re-issued. Minimum latency: load 3 cycles (IDLE,REQ w/ ready,WAIT w/ rsp) + DONE.
//  mem_stall = 1 in REQ and WAIT, and in IDLE when an aligned op is present; 0 in DONE.
//  Stores: B wstrb=0001<<addr[1:0], wdata={4{wdata[7:0]}}; H wstrb=0011<<addr[1:0], wdata={2{wdata[15:0]}}; W wstrb=1111.
//  Loads: select byte/half by addr[1:0]; B/H sign-extend, BU/HU zero-extend; funct3 011/11x treated as W.
//  Timeout: counter counts cycles in REQ+WAIT, cleared on entry; reaching TIMEOUT_CYCLES -> bus_error pulse, drop
//   dmem_req_valid, go DONE with load_valid=0. A late rsp_valid in IDLE is ignored.
//  Reset mid-transaction: immediate return to IDLE, request dropped, no pulse outputs.
// STRUCTURE
//  riscv_mem_pkg: funct3 constants (F3_LB..F3_SW), mau_state_t enum {IDLE,REQ,WAIT,DONE}.
//  Sub-module load_formatter (combinational: rdata, addr[1:0], funct3 -> load_data); shared with any future cache path.
// TESTING
//  1 LW addr 0x100, ready=1, rsp next cycle rdata 0xDEADBEEF -> load_valid pulse, load_data 0xDEADBEEF, stall 3 cycles.
//  2 LB addr 0x103, rdata 0x80112233 -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x00008011.
//  3 SB addr 0x201 wdata 0x000000A5 -> dmem_wstrb 0010, dmem_wdata 0xA5A5A5A5, dmem_addr 0x200, dmem_we 1, no load_valid.
//  4 SW with ready low 5 cycles -> req_valid/addr/wdata stable 5 cycles, mem_stall high throughout, DONE after accept.
//  5 LW addr 0x102 -> misalign_fault pulse, dmem_req_valid never 1, mem_stall 0.
//  6 TIMEOUT_CYCLES=4, LW, rsp never -> bus_error after 4 cycles; reset_n low during WAIT -> IDLE, all outputs 0.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access path.
//  - funct3 encodings for loads and stores
//  - access-unit FSM state type
//  - store lane/strobe helpers and the alignment check
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mau_state_t;

  // Access size comes from funct3[1:0]: 00 byte, 01 half, anything else word.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = addr_lo[0];
      default: is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b00:   store_strobe = 4'b0001 << addr_lo;
      2'b01:   store_strobe = 4'b0011 << addr_lo;
      default: store_strobe = 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across all lanes; the strobe picks the live ones.
  function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3[1:0])
      2'b00:   store_lanes = {4{wdata[7:0]}};
      2'b01:   store_lanes = {2{wdata[15:0]}};
      default: store_lanes = wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter.
// Selects the addressed byte/half of a 32-bit read word and sign- or zero-extends it.
//  i_rdata    raw read word from memory
//  i_addr_lo  byte offset within the word
//  i_funct3   load type (B, H, W, BU, HU; other codes treated as W)
//  o_data     formatted 32-bit result
module load_formatter
  import riscv_mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_data = {24'h000000, w_byte};
      F3_LHU:  o_data = {16'h0000, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit.
// Converts EX/MEM load/store requests into a single valid/ready bus transaction, formats load
// data and stalls the pipeline until the access completes. One access in flight.
//  clk, reset_n                   clock, async active-low reset
//  ex_mem_read/write, ex_addr,
//  ex_wdata, ex_funct3            request from EX/MEM
//  mem_stall                      hold upstream stages
//  dmem_req_*, dmem_we/addr/
//  wdata/wstrb                    bus request channel
//  dmem_rsp_valid, dmem_rdata     bus read response
//  load_data, load_valid          formatted load result + pulse
//  misalign_fault, bus_error      fault pulses
module mem_access_unit
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [2:0]  ex_funct3,
  output logic        mem_stall,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign_fault,
  output logic        bus_error
);

  localparam int unsigned CntW      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic TimeoutEn = (TIMEOUT_CYCLES != 0);

  mau_state_t r_state, w_state_nxt;

  logic            r_we;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_wstrb;
  logic [2:0]      r_funct3;
  logic [CntW-1:0] r_cnt;
  logic [31:0]     r_load_data;
  logic            r_load_valid;
  logic            r_misalign;
  logic            r_bus_error;

  logic        w_op;
  logic        w_mis;
  logic        w_accept;
  logic        w_hs;
  logic        w_timeout;
  logic [31:0] w_load_fmt;

  assign w_op      = ex_mem_read | ex_mem_write;
  assign w_mis     = is_misaligned(ex_funct3, ex_addr[1:0]);
  assign w_accept  = (r_state == IDLE) && w_op && !w_mis;
  assign w_hs      = (r_state == REQ) && dmem_req_ready;
  // Fires on the last permitted cycle of REQ+WAIT; a completion in that cycle still wins.
  assign w_timeout = TimeoutEn && (r_cnt == CntLast);

  load_formatter u_load_formatter (
    .i_rdata   (dmem_rdata),
    .i_addr_lo (r_addr[1:0]),
    .i_funct3  (r_funct3),
    .o_data    (w_load_fmt)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_state_nxt = REQ;
      REQ: begin
        if (w_hs)           w_state_nxt = r_we ? DONE : WAIT;
        else if (w_timeout) w_state_nxt = DONE;
      end
      WAIT: begin
        if (dmem_rsp_valid) w_state_nxt = DONE;
        else if (w_timeout) w_state_nxt = DONE;
      end
      DONE: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_funct3     <= '0;
      r_cnt        <= '0;
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
      r_misalign   <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_load_valid <= 1'b0;
      r_misalign   <= 1'b0;
      r_bus_error  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_op && w_mis) begin
            r_misalign <= 1'b1;
          end else if (w_accept) begin
            r_we     <= ex_mem_write;
            r_addr   <= {ex_addr[31:2], 2'b00};
            r_wdata  <= store_lanes(ex_funct3, ex_wdata);
            r_wstrb  <= ex_mem_write ? store_strobe(ex_funct3, ex_addr[1:0]) : 4'b0000;
            // Keep the byte offset for load lane selection; dmem_addr masks it off.
            r_addr[1:0] <= ex_addr[1:0];
            r_funct3 <= ex_funct3;
            r_cnt    <= '0;
          end
        end
        REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (!w_hs && w_timeout) r_bus_error <= 1'b1;
        end
        WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (dmem_rsp_valid) begin
            r_load_data  <= w_load_fmt;
            r_load_valid <= 1'b1;
          end else if (w_timeout) begin
            r_bus_error <= 1'b1;
          end
        end
        DONE: ;
      endcase
    end
  end

  assign mem_stall      = (r_state == REQ) || (r_state == WAIT) || w_accept;
  assign dmem_req_valid = (r_state == REQ);
  assign dmem_we        = r_we;
  assign dmem_addr      = {r_addr[31:2], 2'b00};
  assign dmem_wdata     = r_wdata;
  assign dmem_wstrb     = r_wstrb;
  assign load_data      = r_load_data;
  assign load_valid     = r_load_valid;
  assign misalign_fault = r_misalign;
  assign bus_error      = r_bus_error;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, backpressure, misalignment, timeout, reset.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_mem_read, ex_mem_write;
  logic [31:0] ex_addr, ex_wdata;
  logic [2:0]  ex_funct3;
  logic        dmem_req_ready, dmem_rsp_valid;
  logic [31:0] dmem_rdata;

  logic        mem_stall, dmem_req_valid, dmem_we, load_valid, misalign_fault, bus_error;
  logic [31:0] dmem_addr, dmem_wdata, load_data;
  logic [3:0]  dmem_wstrb;

  logic        to_mem_stall, to_req_valid, to_we, to_load_valid, to_misalign, to_bus_error;
  logic [31:0] to_addr, to_wdata, to_load_data;
  logic [3:0]  to_wstrb;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset_n(reset_n),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_funct3(ex_funct3), .mem_stall(mem_stall),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata), .load_data(load_data),
    .load_valid(load_valid), .misalign_fault(misalign_fault), .bus_error(bus_error)
  );

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .reset_n(reset_n),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_funct3(ex_funct3), .mem_stall(to_mem_stall),
    .dmem_req_valid(to_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(to_we),
    .dmem_addr(to_addr), .dmem_wdata(to_wdata), .dmem_wstrb(to_wstrb),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata), .load_data(to_load_data),
    .load_valid(to_load_valid), .misalign_fault(to_misalign), .bus_error(to_bus_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Runs one op on the shared inputs from IDLE through DONE, observing the default-timeout DUT.
  // Entered and left at posedge+1; the op is withdrawn after DONE.
  task automatic xact(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [2:0] f3, input int rdy_dly, input logic [31:0] rd,
                      output int n_stall, output int n_req, output bit lv,
                      output logic [31:0] ld, output logic [31:0] q_addr,
                      output logic [31:0] q_wdata, output logic [3:0] q_wstrb,
                      output logic q_we, output int n_unstable, output bit done);
    int  wait_rdy;
    bit  acc, stalled_req;
    n_stall = 0; n_req = 0; lv = 0; ld = '0; q_addr = '0; q_wdata = '0; q_wstrb = '0;
    q_we = 1'b0; n_unstable = 0; done = 0; wait_rdy = rdy_dly;
    ex_mem_read = !wr; ex_mem_write = wr; ex_addr = addr; ex_wdata = wd; ex_funct3 = f3;
    dmem_req_ready = (wait_rdy == 0); dmem_rsp_valid = 1'b0; dmem_rdata = rd;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      acc = 1'b0; stalled_req = 1'b0;
      if (mem_stall) n_stall++;
      if (dmem_req_valid) begin
        if (n_req == 0) begin
          q_addr = dmem_addr; q_wdata = dmem_wdata; q_wstrb = dmem_wstrb; q_we = dmem_we;
        end else if (q_addr !== dmem_addr || q_wdata !== dmem_wdata ||
                     q_wstrb !== dmem_wstrb || q_we !== dmem_we) begin
          n_unstable++;
        end
        n_req++;
        acc = dmem_req_ready;
        stalled_req = !dmem_req_ready;
      end
      if (load_valid) begin lv = 1; ld = load_data; end
      if (c > 0 && !mem_stall) done = 1;
      @(posedge clk); #1;
      dmem_rsp_valid = acc && !wr;
      if (stalled_req) wait_rdy--;
      dmem_req_ready = (wait_rdy <= 0);
    end
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; dmem_rsp_valid = 1'b0;
  endtask

  int          ns, nr, nu;
  bit          lv, dn;
  logic [31:0] ld, qa, qw;
  logic [3:0]  qs;
  logic        qwe;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t lvec[6];

  initial begin
    lvec[0] = '{32'h100, 3'b010, 32'hDEADBEEF, 32'hDEADBEEF};
    lvec[1] = '{32'h103, 3'b000, 32'h80112233, 32'hFFFFFF80};
    lvec[2] = '{32'h103, 3'b100, 32'h80112233, 32'h00000080};
    lvec[3] = '{32'h102, 3'b101, 32'h80112233, 32'h00008011};
    lvec[4] = '{32'h102, 3'b001, 32'h80112233, 32'hFFFF8011};
    lvec[5] = '{32'h101, 3'b000, 32'h80112233, 32'h00000022};

    reset_n = 1'b0;
    ex_mem_read = 0; ex_mem_write = 0; ex_addr = 0; ex_wdata = 0; ex_funct3 = 0;
    dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {28'd0, mem_stall, dmem_req_valid, dmem_we, load_valid}, 32'd0);
    check("rst_flags", {26'd0, misalign_fault, bus_error, dmem_wstrb}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_ldata", load_data, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Loads, ready immediately, response the cycle after acceptance.
    foreach (lvec[i]) begin
      xact(1'b0, lvec[i].addr, 32'h0, lvec[i].f3, 0, lvec[i].rdata,
           ns, nr, lv, ld, qa, qw, qs, qwe, nu, dn);
      check($sformatf("ld%0d_done", i), {31'd0, dn}, 32'd1);
      check($sformatf("ld%0d_stall", i), ns, 32'd3);
      check($sformatf("ld%0d_lvalid", i), {31'd0, lv}, 32'd1);
      check($sformatf("ld%0d_data", i), ld, lvec[i].exp);
      check($sformatf("ld%0d_addr", i), qa, {lvec[i].addr[31:2], 2'b00});
      check($sformatf("ld%0d_we", i), {31'd0, qwe}, 32'd0);
      @(negedge clk);
      check($sformatf("ld%0d_pulse_end", i), {30'd0, load_valid, mem_stall}, 32'd0);
      @(posedge clk); #1;
    end

    // SB to byte 1.
    xact(1'b1, 32'h201, 32'h000000A5, 3'b000, 0, 32'h0, ns, nr, lv, ld, qa, qw, qs, qwe, nu, dn);
    check("sb_done", {31'd0, dn}, 32'd1);
    check("sb_wstrb", {28'd0, qs}, 32'h2);
    check("sb_wdata", qw, 32'hA5A5A5A5);
    check("sb_addr", qa, 32'h200);
    check("sb_we", {31'd0, qwe}, 32'd1);
    check("sb_no_lvalid", {31'd0, lv}, 32'd0);
    check("sb_stall", ns, 32'd2);
    @(negedge clk);
    check("ldata_held", load_data, 32'h00000022);
    @(posedge clk); #1;

    // SH to upper half.
    xact(1'b1, 32'h202, 32'hFFFF1234, 3'b001, 0, 32'h0, ns, nr, lv, ld, qa, qw, qs, qwe, nu, dn);
    check("sh_wstrb", {28'd0, qs}, 32'hC);
    check("sh_wdata", qw, 32'h12341234);

    // SW with ready held low for 5 REQ cycles.
    xact(1'b1, 32'h204, 32'hCAFEF00D, 3'b010, 5, 32'h0, ns, nr, lv, ld, qa, qw, qs, qwe, nu, dn);
    check("sw_done", {31'd0, dn}, 32'd1);
    check("sw_req_cycles", nr, 32'd6);
    check("sw_unstable", nu, 32'd0);
    check("sw_stall", ns, 32'd7);
    check("sw_wstrb", {28'd0, qs}, 32'hF);
    check("sw_wdata", qw, 32'hCAFEF00D);
    check("sw_addr", qa, 32'h204);

    // Misaligned LW: no bus cycle, no stall, fault pulse next cycle.
    dmem_req_ready = 1'b1;
    ex_mem_read = 1'b1; ex_addr = 32'h102; ex_funct3 = 3'b010;
    @(negedge clk);
    check("mis_stall", {31'd0, mem_stall}, 32'd0);
    check("mis_req0", {31'd0, dmem_req_valid}, 32'd0);
    @(posedge clk); #1;
    ex_mem_read = 1'b0;
    @(negedge clk);
    check("mis_fault", {31'd0, misalign_fault}, 32'd1);
    check("mis_req1", {31'd0, dmem_req_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mis_fault_end", {31'd0, misalign_fault}, 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Timeout on the TIMEOUT_CYCLES=4 instance: response never arrives.
    ex_mem_read = 1'b1; ex_addr = 32'h300; ex_funct3 = 3'b010;
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("to_stall_c%0d", c), {31'd0, to_mem_stall}, 32'd1);
      if (c == 1) check("to_req_c1", {31'd0, to_req_valid}, 32'd1);
      if (c > 0) check($sformatf("to_noerr_c%0d", c), {31'd0, to_bus_error}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("to_bus_error", {31'd0, to_bus_error}, 32'd1);
    check("to_no_lvalid", {31'd0, to_load_valid}, 32'd0);
    check("to_done_ctl", {30'd0, to_mem_stall, to_req_valid}, 32'd0);
    check("long_wait_stall", {31'd0, mem_stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("to_err_end", {31'd0, to_bus_error}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("to_wait_stall", {30'd0, to_mem_stall, to_req_valid}, 32'd2);

    // Reset mid-WAIT on both instances.
    #2;
    ex_mem_read = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_to_ctl", {22'd0, to_mem_stall, to_req_valid, to_we, to_load_valid, to_misalign,
                         to_bus_error, to_wstrb}, 32'd0);
    check("rst_to_addr", to_addr, 32'd0);
    check("rst_to_wdata", to_wdata, 32'd0);
    check("rst_dut_ctl", {22'd0, mem_stall, dmem_req_valid, dmem_we, load_valid, misalign_fault,
                          bus_error, dmem_wstrb}, 32'd0);
    check("rst_dut_ldata", load_data, 32'd0);
    check("rst_dut_wdata", dmem_wdata, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_idle", {28'd0, mem_stall, dmem_req_valid, to_mem_stall, to_req_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
